main_memory_block_reader: RTL and testbench

Sits directly downstream of instruction_cache_controller and serves its miss requests. It accepts a block-read request, aligns the address to a 16-byte block, and fetches the four 32-bit words one at a time over a single-outstanding word interface to main memory. It assembles the 128-bit block and returns it with a one-cycle ready pulse. A per-word timeout reports a memory error instead of hanging the fetch path.

---
 rtl/main_memory_block_reader.sv | 128 ++++++++++++
 tb/tb_main_memory_block_reader.sv | 310 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/main_memory_block_reader.sv
// ============================================================================
//  Module      : main_memory_block_reader
//  Description : Serves block-read misses from the instruction cache
//                controller. Aligns the request to a block boundary, fetches
//                the block one word at a time over a single-outstanding word
//                interface, assembles it and returns it with a one-cycle
//                ready pulse. A per-word timeout turns a silent memory into a
//                one-cycle error pulse instead of a hung fetch path.
//  Ports       :
//    clk_i, rst_i                                   clock, async active-low reset
//    anabellek_denetleyici_okuma_istek_adres_i      block-read address
//    anabellek_denetleyici_okuma_istek_gecerli_i    block-read request strobe
//    anabellek_denetleyici_okuma_veri_blok_o        assembled block
//    anabellek_denetleyici_okuma_istek_hazir_o      block valid pulse
//    anabellek_denetleyici_okuma_hata_o             timeout error pulse
//    anabellek_istek_adres_o / _gecerli_o           word request to memory
//    anabellek_istek_hazir_i                        memory accepts request
//    anabellek_yanit_veri_i / _gecerli_i            word response from memory
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module main_memory_block_reader #(
    parameter int ADRES_BIT   = 32,
    parameter int VERI_BIT    = 32,
    parameter int BLOK_BIT    = 128,
    parameter int ZAMAN_ASIMI = 255
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic [ADRES_BIT-1:0] anabellek_denetleyici_okuma_istek_adres_i,
    input  logic                 anabellek_denetleyici_okuma_istek_gecerli_i,
    output logic [BLOK_BIT-1:0]  anabellek_denetleyici_okuma_veri_blok_o,
    output logic                 anabellek_denetleyici_okuma_istek_hazir_o,
    output logic                 anabellek_denetleyici_okuma_hata_o,
    output logic [ADRES_BIT-1:0] anabellek_istek_adres_o,
    output logic                 anabellek_istek_gecerli_o,
    input  logic                 anabellek_istek_hazir_i,
    input  logic [VERI_BIT-1:0]  anabellek_yanit_veri_i,
    input  logic                 anabellek_yanit_gecerli_i
);

    localparam int c_KELIME_SAYISI = BLOK_BIT / VERI_BIT;
    localparam int c_SAYAC_BIT     = $clog2(c_KELIME_SAYISI);
    localparam int c_KELIME_KAYMA  = $clog2(VERI_BIT / 8);

    // Clears the byte-within-block bits so every fetch starts at word 0.
    localparam logic [ADRES_BIT-1:0]   c_HIZA_MASKE  = ~ADRES_BIT'(BLOK_BIT / 8 - 1);
    localparam logic [7:0]             c_ZAMAN_SINIR = 8'(ZAMAN_ASIMI);
    localparam logic [c_SAYAC_BIT-1:0] c_SON_KELIME  = c_SAYAC_BIT'(c_KELIME_SAYISI - 1);

    localparam logic [2:0] c_BOSTA = 3'd0;
    localparam logic [2:0] c_ISTEK = 3'd1;
    localparam logic [2:0] c_BEKLE = 3'd2;
    localparam logic [2:0] c_TAMAM = 3'd3;
    localparam logic [2:0] c_HATA  = 3'd4;

    logic [2:0]             r_durum;
    logic [c_SAYAC_BIT-1:0] r_sayac;
    logic [7:0]             r_zaman;
    logic [ADRES_BIT-1:0]   r_taban;
    logic [BLOK_BIT-1:0]    r_blok;

    logic [ADRES_BIT-1:0]   w_kelime_adres;
    logic [7:0]             w_zaman_sonraki;

    // The base is block aligned, so base + word offset never carries out of
    // the block, and the top block wraps cleanly modulo 2^ADRES_BIT.
    assign w_kelime_adres  = r_taban + (ADRES_BIT'(r_sayac) << c_KELIME_KAYMA);
    assign w_zaman_sonraki = r_zaman + 8'd1;

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_durum <= c_BOSTA;
            r_sayac <= '0;
            r_zaman <= '0;
            r_taban <= '0;
            r_blok  <= '0;
        end else begin
            case (r_durum)
                c_BOSTA: begin
                    if (anabellek_denetleyici_okuma_istek_gecerli_i) begin
                        r_taban <= anabellek_denetleyici_okuma_istek_adres_i & c_HIZA_MASKE;
                        r_sayac <= '0;
                        r_blok  <= '0;
                        r_durum <= c_ISTEK;
                    end
                end
                c_ISTEK: begin
                    // Valid is a pure state decode, so it cannot drop until
                    // the handshake moves us out of this state.
                    if (anabellek_istek_hazir_i) begin
                        r_zaman <= '0;
                        r_durum <= c_BEKLE;
                    end
                end
                c_BEKLE: begin
                    // A response always wins over a timeout in the same cycle.
                    if (anabellek_yanit_gecerli_i) begin
                        r_blok[int'(r_sayac) * VERI_BIT +: VERI_BIT] <= anabellek_yanit_veri_i;
                        if (r_sayac == c_SON_KELIME) begin
                            r_durum <= c_TAMAM;
                        end else begin
                            r_sayac <= r_sayac + c_SAYAC_BIT'(1);
                            r_durum <= c_ISTEK;
                        end
                    end else if (w_zaman_sonraki == c_ZAMAN_SINIR) begin
                        r_durum <= c_HATA;
                    end else begin
                        r_zaman <= w_zaman_sonraki;
                    end
                end
                c_TAMAM: r_durum <= c_BOSTA;
                c_HATA:  r_durum <= c_BOSTA;
                default: r_durum <= c_BOSTA;
            endcase
        end
    end

    assign anabellek_denetleyici_okuma_veri_blok_o   = r_blok;
    assign anabellek_denetleyici_okuma_istek_hazir_o = (r_durum == c_TAMAM);
    assign anabellek_denetleyici_okuma_hata_o        = (r_durum == c_HATA);
    assign anabellek_istek_gecerli_o                 = (r_durum == c_ISTEK);
    assign anabellek_istek_adres_o                   = w_kelime_adres;

endmodule

`default_nettype wire

// File: tb/tb_main_memory_block_reader.sv
// ============================================================================
//  Module      : tb_main_memory_block_reader
//  Description : Self-checking bench for main_memory_block_reader. A table of
//                block reads plus hand-written sequences for timeout, reset
//                and protocol corner cases; a scoreboard queue holds expected
//                outcomes and word addresses.
//  Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_main_memory_block_reader;

    logic         clk_i = 1'b0;
    logic         rst_i;
    logic [31:0]  i_adres;
    logic         i_gecerli;
    logic [127:0] o_blok;
    logic         o_hazir;
    logic         o_hata;
    logic [31:0]  o_adres;
    logic         o_gecerli;
    logic         mem_hazir;
    logic [31:0]  yanit_veri;
    logic         yanit_gecerli;

    always #5 clk_i = ~clk_i;

    main_memory_block_reader dut (
        .clk_i                                       (clk_i),
        .rst_i                                       (rst_i),
        .anabellek_denetleyici_okuma_istek_adres_i   (i_adres),
        .anabellek_denetleyici_okuma_istek_gecerli_i (i_gecerli),
        .anabellek_denetleyici_okuma_veri_blok_o     (o_blok),
        .anabellek_denetleyici_okuma_istek_hazir_o   (o_hazir),
        .anabellek_denetleyici_okuma_hata_o          (o_hata),
        .anabellek_istek_adres_o                     (o_adres),
        .anabellek_istek_gecerli_o                   (o_gecerli),
        .anabellek_istek_hazir_i                     (mem_hazir),
        .anabellek_yanit_veri_i                      (yanit_veri),
        .anabellek_yanit_gecerli_i                   (yanit_gecerli)
    );

    typedef struct {
        logic [31:0]  adres;
        logic [31:0]  tuz;
        int           stall_kelime;
        int           stall_n;
        int           gecikme;
        logic [127:0] blok;
    } vektor_t;

    typedef struct {
        logic         hata;
        int           gecikme;
        logic [127:0] blok;
        int           kabul;
    } beklenen_t;

    beklenen_t    sb_q[$];
    logic [31:0]  adr_q[$];
    vektor_t      tablo[5];

    int           n_test = 0;
    int           n_fail = 0;
    int           cyc = 0;
    int           n_hazir = 0;
    int           n_hata = 0;
    int           hs_idx = 0;
    int           stall_kelime = -1;
    int           stall_kalan = 0;
    int           dusur_kelime = -1;
    logic [31:0]  cur_tuz = '0;
    logic         yanit_bekliyor = 1'b0;
    logic [31:0]  yanit_sonraki = '0;
    logic         hs_bekliyor = 1'b0;
    logic [31:0]  bekleyen_adres = '0;
    logic         sahte_yanit = 1'b0;

    // Memory content: word index + 1 replicated in every nibble, xor a salt.
    function automatic logic [31:0] kelime(input logic [31:0] a, input logic [31:0] tuz);
        logic [3:0] n;
        n = 4'(a[3:2]) + 4'd1;
        return {8{n}} ^ tuz;
    endfunction

    task automatic kontrol(input string ad, input logic [127:0] gercek, input logic [127:0] beklenen);
        n_test++;
        if (gercek !== beklenen) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", ad, gercek, beklenen, cyc);
        end
    endtask

    // Drives memory-side inputs for the rest of the current cycle based on
    // the DUT outputs visible now.
    task automatic model_surus();
        yanit_gecerli = 1'b0;
        mem_hazir     = 1'b0;
        if (yanit_bekliyor) begin
            yanit_gecerli  = 1'b1;
            yanit_veri     = yanit_sonraki;
            yanit_bekliyor = 1'b0;
        end else if (sahte_yanit) begin
            yanit_gecerli = 1'b1;
            yanit_veri    = 32'hDEADBEEF;
            sahte_yanit   = 1'b0;
        end
        if (hs_bekliyor) begin
            kontrol("valid_held", o_gecerli, 1);
            kontrol("addr_held", o_adres, bekleyen_adres);
        end
        if (o_gecerli) begin
            if (hs_idx == stall_kelime && stall_kalan > 0) begin
                stall_kalan--;
                if (!hs_bekliyor) bekleyen_adres = o_adres;
                hs_bekliyor = 1'b1;
            end else begin
                mem_hazir   = 1'b1;
                hs_bekliyor = 1'b0;
                if (adr_q.size() == 0) kontrol("unexpected_req", 1, 0);
                else                   kontrol("word_addr", o_adres, adr_q.pop_front());
                if (hs_idx != dusur_kelime) begin
                    yanit_bekliyor = 1'b1;
                    yanit_sonraki  = kelime(o_adres, cur_tuz);
                end
                hs_idx++;
            end
        end else begin
            hs_bekliyor = 1'b0;
        end
    endtask

    task automatic gozlem();
        beklenen_t e;
        if (o_hazir || o_hata) begin
            if (o_hazir) n_hazir++;
            if (o_hata)  n_hata++;
            if (sb_q.size() == 0) begin
                kontrol("unexpected_done", {o_hazir, o_hata}, 0);
            end else begin
                e = sb_q.pop_front();
                kontrol("done_kind", {o_hazir, o_hata}, e.hata ? 2'b01 : 2'b10);
                kontrol("latency", cyc - e.kabul, e.gecikme);
                if (!e.hata) kontrol("block", o_blok, e.blok);
                else         adr_q.delete();
            end
        end
    endtask

    task automatic step();
        model_surus();
        @(posedge clk_i);
        @(negedge clk_i);
        cyc++;
        gozlem();
    endtask

    task automatic istek(input logic [31:0] adres, input logic [31:0] tuz,
                         input logic [127:0] blok, input int gecikme, input logic hata);
        logic [31:0] taban;
        cur_tuz = tuz;
        hs_idx  = 0;
        taban   = {adres[31:4], 4'h0};
        for (int i = 0; i < 4; i++) adr_q.push_back(taban + 32'(4 * i));
        sb_q.push_back('{hata: hata, gecikme: gecikme, blok: blok, kabul: cyc});
        i_adres   = adres;
        i_gecerli = 1'b1;
        step();
        i_gecerli = 1'b0;
        i_adres   = $urandom;
    endtask

    // Runs until every expected outcome is seen, then one more cycle so the
    // next request lands in the first BOSTA cycle.
    task automatic bosalt(input int sinir);
        for (int i = 0; i < sinir && sb_q.size() > 0; i++) step();
        if (sb_q.size() > 0) begin
            kontrol("drain_timeout", sb_q.size(), 0);
            sb_q.delete();
        end
        step();
        kontrol("addr_q_empty", adr_q.size(), 0);
        adr_q.delete();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int h0;
        int e0;
        logic [127:0] saklanan;

        tablo[0] = '{32'h0000_1234, 32'h0000_0000, -1, 0, 9,
                     128'h44444444_33333333_22222222_11111111};
        tablo[1] = '{32'h0000_1234, 32'h0F0F_0F0F, 2, 5, 14,
                     128'h4B4B4B4B_3C3C3C3C_2D2D2D2D_1E1E1E1E};
        tablo[2] = '{32'hFFFF_FFFC, 32'hA5A5_A5A5, -1, 0, 9,
                     128'hE1E1E1E1_96969696_87878787_B4B4B4B4};
        tablo[3] = '{32'hABCD_EF0F, 32'h1234_5678, 0, 2, 11,
                     128'h5670123C_2107654B_3016745A_03254769};
        tablo[4] = '{32'h0000_0008, 32'h0000_0000, 3, 1, 10,
                     128'h44444444_33333333_22222222_11111111};

        rst_i         = 1'b0;
        i_adres       = '0;
        i_gecerli     = 1'b0;
        mem_hazir     = 1'b0;
        yanit_veri    = '0;
        yanit_gecerli = 1'b0;
        repeat (3) @(negedge clk_i);

        kontrol("rst_block", o_blok, 0);
        kontrol("rst_hazir", o_hazir, 0);
        kontrol("rst_hata", o_hata, 0);
        kontrol("rst_valid", o_gecerli, 0);
        kontrol("rst_addr", o_adres, 0);
        rst_i = 1'b1;
        step();

        // Table of normal block reads, back to back.
        foreach (tablo[k]) begin
            stall_kelime = tablo[k].stall_kelime;
            stall_kalan  = tablo[k].stall_n;
            h0 = n_hazir;
            istek(tablo[k].adres, tablo[k].tuz, tablo[k].blok, tablo[k].gecikme, 1'b0);
            bosalt(100);
            kontrol("one_hazir", n_hazir - h0, 1);
        end
        stall_kelime = -1;
        stall_kalan  = 0;

        // Word 1 never answered: error after 255 waiting cycles, no ready.
        dusur_kelime = 1;
        h0 = n_hazir;
        e0 = n_hata;
        istek(32'h0000_2000, 32'h0, 128'h0, 3 + 255 + 1, 1'b1);
        bosalt(400);
        dusur_kelime = -1;
        kontrol("timeout_no_hazir", n_hazir - h0, 0);
        kontrol("timeout_one_hata", n_hata - e0, 1);
        istek(32'h0000_3004, 32'h0, 128'h44444444_33333333_22222222_11111111, 9, 1'b0);
        bosalt(100);

        // Asynchronous reset in the middle of word 2's wait.
        dusur_kelime = 2;
        istek(32'h0000_4560, 32'h0, 128'h0, 9, 1'b0);
        for (int i = 0; i < 50 && hs_idx < 3; i++) step();
        kontrol("reach_word2", hs_idx, 3);
        step();
        kontrol("pre_reset_word0", o_blok[31:0], kelime(32'h0000_4560, 32'h0));
        #2;
        rst_i = 1'b0;
        #1;
        kontrol("async_rst_block", o_blok, 0);
        kontrol("async_rst_valid", o_gecerli, 0);
        kontrol("async_rst_addr", o_adres, 0);
        kontrol("async_rst_hazir", o_hazir, 0);
        sb_q.delete();
        adr_q.delete();
        yanit_bekliyor = 1'b0;
        hs_bekliyor    = 1'b0;
        dusur_kelime   = -1;
        mem_hazir      = 1'b0;
        yanit_gecerli  = 1'b0;
        @(posedge clk_i);
        @(negedge clk_i);
        rst_i = 1'b1;
        h0 = n_hazir;
        sahte_yanit = 1'b1;
        step();
        step();
        kontrol("late_resp_block", o_blok, 0);
        kontrol("late_resp_no_hazir", n_hazir - h0, 0);
        istek(32'h0000_4560, 32'hFFFF_FFFF,
              128'hBBBBBBBB_CCCCCCCC_DDDDDDDD_EEEEEEEE, 9, 1'b0);
        bosalt(100);

        // Second request while busy, then a stray response in BOSTA.
        h0 = n_hazir;
        istek(32'h0000_5000, 32'h5A5A_5A5A,
              128'h1E1E1E1E_69696969_78787878_4B4B4B4B, 9, 1'b0);
        step();
        step();
        i_adres   = 32'h0000_6000;
        i_gecerli = 1'b1;
        step();
        i_gecerli = 1'b0;
        bosalt(100);
        kontrol("busy_one_hazir", n_hazir - h0, 1);
        saklanan = o_blok;
        kontrol("held_block", saklanan, 128'h1E1E1E1E_69696969_78787878_4B4B4B4B);
        sahte_yanit = 1'b1;
        step();
        step();
        step();
        kontrol("stray_resp_block", o_blok, 128'h1E1E1E1E_69696969_78787878_4B4B4B4B);
        kontrol("stray_resp_no_hazir", n_hazir - h0, 1);

        $display("[TB] %0d tests run, %0d failed", n_test, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
